pin_sender: RTL and testbench

Initiator side of the 2-bit-digit PIN entry interface: takes an 8-bit PIN (four 2-bit digits) and serialises it onto the `digit`/`submit` strobe interface consumed by the PIN checker. It then waits for the checker's `correct`/`incorrect` verdict, with a bounded timeout, and reports the result. It sits between keypad/host logic and the checker, in the same clock domain.

---
 rtl/pin_pkg.sv | 27 ++
 rtl/pin_gap_timer.sv | 32 +++
 rtl/pin_sender.sv | 204 ++++++++++++++++++++
 tb/tb_pin_sender.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// pin_pkg: shared definitions for the PIN sender slice.
//   - state_t   : sender FSM states
//   - PIN_DIGITS: digits per PIN entry
//   - DIGIT_W   : bits per digit
//   - pin_digit : extracts digit[idx] from a packed PIN, digit 0 in the MSBs
package pin_pkg;

  localparam int PIN_DIGITS = 4;
  localparam int DIGIT_W    = 2;
  localparam int PIN_W      = PIN_DIGITS * DIGIT_W;
  localparam int IDX_W      = $clog2(PIN_DIGITS);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    WAIT_RESP,
    DONE
  } state_t;

  // Digit 0 is sent first and lives in the top bits of the PIN.
  function automatic logic [DIGIT_W-1:0] pin_digit(input logic [PIN_W-1:0] p,
                                                   input logic [IDX_W-1:0] idx);
    return p[(PIN_DIGITS - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/pin_gap_timer.sv
// pin_gap_timer: loadable down-counter shared by the inter-digit gap and the
// verdict timeout.
//   clk      in  clock, rising edge
//   reset    in  synchronous active-high reset (count -> 0)
//   load     in  load load_val this cycle
//   load_val in  value loaded; the timer then spans load_val+1 cycles
//   expired  out count has reached 0
module pin_gap_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pin_sender.sv
// pin_sender: serialises an 8-bit PIN (four 2-bit digits, pin[7:6] first) onto
// the digit/submit strobe interface of the PIN checker, then waits a bounded
// time for the correct/incorrect verdict and reports it.
//
// Optional feature: define PIN_SENDER_LOCKOUT_EN to lock out further entries
// after MAX_FAILS consecutive failed verdicts (cleared only by reset).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request to send pin (honoured only in IDLE)
//   pin        in   [7:0] four digits
//   waiting    in   checker ready for a new entry
//   correct    in   checker verdict: match
//   incorrect  in   checker verdict: mismatch (wins over correct)
//   digit      out  [1:0] digit presented to the checker
//   submit     out  one-cycle strobe, digit valid
//   busy       out  high from acceptance through DONE
//   done       out  one-cycle result pulse
//   pass/fail/timeout out sticky result flags
//   locked     out  lockout active
// All outputs are registered.
module pin_sender
  import pin_pkg::*;
#(
  parameter int DIGIT_GAP    = 4,
  parameter int RESP_TIMEOUT = 16,
  parameter int MAX_FAILS    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PIN_W-1:0]   pin,
  input  logic               waiting,
  input  logic               correct,
  input  logic               incorrect,
  output logic [DIGIT_W-1:0] digit,
  output logic               submit,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic               locked
);

  localparam int TMR_MAX = (DIGIT_GAP > RESP_TIMEOUT) ? DIGIT_GAP : RESP_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(DIGIT_GAP - 1);
  localparam logic [TMR_W-1:0] RESP_LOAD = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIN_DIGITS - 1);

  state_t             state_q, next_state;
  logic [IDX_W-1:0]   idx_q, next_idx;
  logic [PIN_W-1:0]   pin_q;
  logic               accept;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expired;
  logic               res_pass, res_fail, res_tmo;
  logic               locked_q;

  pin_gap_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= next_state;
      idx_q   <= next_idx;
    end
  end

  // The timer is loaded on the transition into GAP / WAIT_RESP so that the
  // count is already valid in the first cycle of the state.
  always_comb begin
    next_state = state_q;
    next_idx   = idx_q;
    accept     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    res_pass   = 1'b0;
    res_fail   = 1'b0;
    res_tmo    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && waiting && !locked_q) begin
          accept     = 1'b1;
          next_idx   = '0;
          next_state = SEND;
        end
      end
      SEND: begin
        tmr_load   = 1'b1;
        tmr_val    = GAP_LOAD;
        next_state = GAP;
      end
      GAP: begin
        if (tmr_expired) begin
          if (idx_q < LAST_IDX) begin
            next_idx   = idx_q + 1'b1;
            next_state = SEND;
          end else begin
            tmr_load   = 1'b1;
            tmr_val    = RESP_LOAD;
            next_state = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        // A verdict in the last timer cycle still beats the timeout.
        if (incorrect) begin
          res_fail   = 1'b1;
          next_state = DONE;
        end else if (correct) begin
          res_pass   = 1'b1;
          next_state = DONE;
        end else if (tmr_expired) begin
          res_tmo    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode, so each strobe is high
  // exactly in the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_q   <= '0;
      digit   <= '0;
      submit  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      submit <= (next_state == SEND);
      busy   <= (next_state != IDLE);
      done   <= (next_state == DONE);
      if (accept) begin
        pin_q <= pin;
      end
      if (next_state == IDLE || next_state == DONE) begin
        digit <= '0;
      end else if (next_state == SEND) begin
        digit <= pin_digit(accept ? pin : pin_q, next_idx);
      end
      if (accept) begin
        pass    <= 1'b0;
        fail    <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (res_pass) pass    <= 1'b1;
        if (res_fail) fail    <= 1'b1;
        if (res_tmo)  timeout <= 1'b1;
      end
    end
  end

`ifdef PIN_SENDER_LOCKOUT_EN
  logic [1:0] fail_cnt_q;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  // Timeouts leave the consecutive-fail count untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (res_fail) begin
      fail_cnt_q <= sat_inc(fail_cnt_q);
      if (int'(sat_inc(fail_cnt_q)) >= MAX_FAILS) begin
        locked_q <= 1'b1;
      end
    end else if (res_pass) begin
      fail_cnt_q <= '0;
    end
  end
`else
  logic unused_max_fails;
  assign unused_max_fails = (MAX_FAILS > 0);
  assign locked_q         = 1'b0;
`endif

  assign locked = locked_q;

endmodule

// File: tb/tb_pin_sender.sv
// tb_pin_sender: directed scoreboard bench for pin_sender (default parameters).
// Stimulus pushes the hand-computed submit/done events into a queue; a monitor
// pops and compares them whenever the DUT strobes submit or done.
module tb_pin_sender;

  logic       clk = 1'b0;
  logic       reset, start, waiting, correct, incorrect;
  logic [7:0] pin;
  logic [1:0] digit;
  logic       submit, busy, done, pass, fail, timeout, locked;

`ifdef PIN_SENDER_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  pin_sender dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pin       (pin),
    .waiting   (waiting),
    .correct   (correct),
    .incorrect (incorrect),
    .digit     (digit),
    .submit    (submit),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit       is_done;
    int       rel;
    logic [2:0] val;  // digit for submit, {pass,fail,timeout} for done
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT strobed with no pending expectation (cycle %0d)", name, cyc - base);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (submit) begin
      if (sb.size() == 0) unexpected("submit");
      else begin
        e = sb.pop_front();
        check("submit order", 0, int'(e.is_done));
        check("submit cycle", cyc - base, e.rel);
        check("submit digit", int'(digit), int'(e.val));
      end
    end
    if (done) begin
      if (sb.size() == 0) unexpected("done");
      else begin
        e = sb.pop_front();
        check("done order", 1, int'(e.is_done));
        check("done cycle", cyc - base, e.rel);
        check("done flags", int'({pass, fail, timeout}), int'(e.val));
        check("done digit", int'(digit), 0);
        check("done busy", int'(busy), 1);
      end
    end
  end

  task automatic push_submits(input logic [7:0] p, input int n);
    exp_t e;
    logic [7:0] q;
    q = p;
    for (int k = 0; k < n; k++) begin
      e.is_done = 1'b0;
      e.rel     = 1 + k * 5;
      e.val     = {1'b0, q[7:6]};
      sb.push_back(e);
      q = q << 2;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({digit, submit, busy, done, pass, fail, timeout, locked}), 0);
  endtask

  // vc<0: no verdict. done_c and flags are hand-computed by the caller.
  task automatic txn(input logic [7:0] p, input int vc, input bit vcor,
                     input bit vinc, input int done_c, input logic [2:0] flags,
                     input bit exp_lock, input bit noise);
    exp_t e;
    @(negedge clk);
    pin   = p;
    start = 1'b1;
    base  = cyc;
    push_submits(p, 4);
    e.is_done = 1'b1;
    e.rel     = done_c;
    e.val     = flags;
    sb.push_back(e);
    @(negedge clk);
    for (int k = 1; k <= done_c; k++) begin
      correct   = ((k == vc) && vcor) || (noise && k == 8);
      incorrect = (k == vc) && vinc;
      start     = noise && (k == 3 || k == 12);
      if (noise && k == 5) pin = ~p;
      if (k == 1) begin
        check("flags clear on accept", int'({pass, fail, timeout}), 0);
        check("busy after accept", int'(busy), 1);
      end
      if (k == done_c) check("locked at done", int'(locked), int'(exp_lock));
      @(negedge clk);
    end
    correct   = 1'b0;
    incorrect = 1'b0;
    start     = 1'b0;
    check("busy after done", int'(busy), 0);
    check("sticky flags", int'({pass, fail, timeout}), int'(flags));
    check("scoreboard drained", sb.size(), 0);
  endtask

  task automatic ignored_start(input string name);
    @(negedge clk);
    start = 1'b1;
    base  = cyc;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check(name, int'(busy), 0);
    repeat (20) @(negedge clk);
    check("no output after ignored start", int'(submit | done | busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; waiting = 1'b1;
    correct = 1'b0; incorrect = 1'b0; pin = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("outputs in reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("outputs after reset");

    // correct in cycle 23 -> pass at 24; digits 0,2,0,2
    txn(8'b00_10_00_10, 23, 1'b1, 1'b0, 24, 3'b100, 1'b0, 1'b0);
    // incorrect in cycle 22 -> fail at 23
    txn(8'b00_10_00_10, 22, 1'b0, 1'b1, 23, 3'b010, 1'b0, 1'b0);
    // both verdicts together -> fail wins
    txn(8'b11_01_10_00, 22, 1'b1, 1'b1, 23, 3'b010, 1'b0, 1'b0);
    // no verdict -> timeout at 37
    txn(8'b10_11_01_00, -1, 1'b0, 1'b0, 37, 3'b001, 1'b0, 1'b0);
    // pin changes at 5, start while busy, verdict during GAP: all ignored
    txn(8'b01_11_00_10, 30, 1'b1, 1'b0, 31, 3'b100, 1'b0, 1'b1);
    // verdict in the last WAIT_RESP cycle beats the timeout
    txn(8'b11_11_11_11, 36, 1'b1, 1'b0, 37, 3'b100, 1'b0, 1'b0);

    // start while checker not waiting
    waiting = 1'b0;
    ignored_start("start ignored when not waiting");
    waiting = 1'b1;

    // reset in cycle 8 aborts the entry
    @(negedge clk);
    pin   = 8'b11_01_10_00;
    start = 1'b1;
    base  = cyc;
    push_submits(8'b11_01_10_00, 2);
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("outputs after mid-op reset");
    repeat (40) @(negedge clk);
    check("no done after abort", sb.size(), 0);
    check("idle after abort", int'(busy), 0);

    txn(8'b01_00_11_10, 25, 1'b1, 1'b0, 26, 3'b100, 1'b0, 1'b0);

    // consecutive fails, with a timeout in between that must not reset the count
    txn(8'b10_10_10_10, 21, 1'b0, 1'b1, 22, 3'b010, 1'b0, 1'b0);
    txn(8'b10_10_10_10, 30, 1'b0, 1'b1, 31, 3'b010, 1'b0, 1'b0);
    txn(8'b10_10_10_10, -1, 1'b0, 1'b0, 37, 3'b001, 1'b0, 1'b0);
    txn(8'b10_10_10_10, 24, 1'b0, 1'b1, 25, 3'b010, LOCK_EN, 1'b0);
    if (LOCK_EN) begin
      ignored_start("start ignored when locked");
      check("still locked", int'(locked), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("lock cleared by reset");
    end else begin
      check("never locked", int'(locked), 0);
    end
    txn(8'b00_01_10_11, 23, 1'b1, 1'b0, 24, 3'b100, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("final scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
